// File: rtl/encoder_16x4_arb_pkg.sv
// encoder_pkg: shared constants, FSM states and onehot helper for the 16x4 encoder/decoder pair
package encoder_pkg;
  localparam int N = 16;
  localparam int IW = 4;
  localparam int OH_W = N;
  localparam int IDX_W = IW;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [OH_W-1:0] onehot(input logic [IDX_W-1:0] i);
    return OH_W'(1) << i;
  endfunction
endpackage

// File: rtl/encoder_16x4_arb_if.sv
// encoder_16x4_arb_if: request capture and grant handshake bundle
interface encoder_16x4_arb_if import encoder_pkg::*; ();
  logic enable;
  logic [N-1:0] req;
  logic ack;
  logic [IW-1:0] idx;
  logic valid;
  logic [N-1:0] pending;
  modport master(output enable, req, ack, input idx, valid, pending);
  modport slave(input enable, req, ack, output idx, valid, pending);
endinterface

// File: rtl/encoder_16x4_arb_prio_enc16.sv
// prio_enc16: combinational priority encoder searching downward from start, wrapping 0 to 15
module prio_enc16 import encoder_pkg::*; (
  input  logic [N-1:0]  v_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // farthest-from-start candidates first so the nearest set bit is assigned last
  always_comb begin
    idx_o = '0;
    any_o = |v_i;
    for (int i = N - 1; i >= 0; i--)
      if (v_i[start_i - IW'(i)]) idx_o = start_i - IW'(i);
  end
endmodule

// File: rtl/encoder_16x4_arb.sv
// encoder_16x4_arb: registered 16-to-4 request encoder with valid/ack grant handshake
// ENCODER_ROUND_ROBIN_EN selects rotating priority instead of fixed highest-index priority
module encoder_16x4_arb import encoder_pkg::*; (
  input logic clk,
  input logic reset_n,
  encoder_16x4_arb_if.slave bus
);
  state_t state_q, state_d;
  logic [N-1:0] pending_q, pending_d, ackmask;
  logic [IW-1:0] idx_q, idx_d, enc_idx, start;
  logic enc_any, accept, load;
  assign accept = (state_q == GRANT) && bus.ack;
  assign ackmask = accept ? onehot(idx_q) : '0;
  assign pending_d = (pending_q & ~ackmask) | (bus.enable ? bus.req : '0);
  assign load = (state_q == IDLE) || bus.ack;
`ifdef ENCODER_ROUND_ROBIN_EN
  logic [IW-1:0] rr_q, rr_d;
  // search for the next grant must already start below the index being accepted
  assign rr_d = accept ? idx_q - 1'b1 : rr_q;
  assign start = rr_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rr_q <= '1;
    else rr_q <= rr_d;
`else
  assign start = '1;
`endif
  prio_enc16 u_enc (
    .v_i(pending_d),
    .start_i(start),
    .idx_o(enc_idx),
    .any_o(enc_any)
  );
  always_comb begin
    state_d = load ? (enc_any ? GRANT : IDLE) : state_q;
    idx_d = (load && enc_any) ? enc_idx : idx_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      pending_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pending_q <= pending_d;
    end
  assign bus.idx = idx_q;
  assign bus.valid = state_q == GRANT;
  assign bus.pending = pending_q;
endmodule

// File: tb/tb_encoder_16x4_arb.sv
// tb_encoder_16x4_arb: directed table, corner sequences and randomized model check for encoder_16x4_arb
module tb_encoder_16x4_arb;
  typedef struct {
    logic en;
    logic [15:0] req;
    logic ack;
    logic v;
    logic [3:0] idx;
    logic [15:0] pend;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int failed = 0;
  logic m_valid;
  int m_idx;
  int m_ptr;
  logic [15:0] m_pend;
  vec_t tbl[14];
  encoder_16x4_arb_if bus();
  encoder_16x4_arb dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] p, input int ptr);
    for (int i = 0; i < 16; i++) begin
      int j = (ptr - i + 16) % 16;
      if (p[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx = 0;
    m_ptr = 15;
    m_pend = '0;
  endtask

  task automatic model_step(input logic e, input logic [15:0] r, input logic a);
    if (m_valid && a) begin
      m_pend[m_idx] = 1'b0;
`ifdef ENCODER_ROUND_ROBIN_EN
      m_ptr = (m_idx + 15) % 16;
`endif
    end
    if (e) m_pend = m_pend | r;
    if (!m_valid || a) begin
      if (m_pend != 0) begin
        m_idx = pick(m_pend, m_ptr);
        m_valid = 1'b1;
      end else m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic e, input logic [15:0] r, input logic a);
    bus.enable = e;
    bus.req = r;
    bus.ack = a;
    @(posedge clk);
    model_step(e, r, a);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.enable = 1'b0;
    bus.req = '0;
    bus.ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 4'd0,  16'h0001};
    tbl[1]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[2]  = '{1'b1, 16'h8421, 1'b1, 1'b1, 4'd15, 16'h8421};
    tbl[3]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd10, 16'h0421};
    tbl[4]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd5,  16'h0021};
    tbl[5]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd0,  16'h0001};
    tbl[6]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[7]  = '{1'b1, 16'h0020, 1'b0, 1'b1, 4'd5,  16'h0020};
    tbl[8]  = '{1'b1, 16'h1000, 1'b0, 1'b1, 4'd5,  16'h1020};
    tbl[9]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd12, 16'h1000};
    tbl[10] = '{1'b1, 16'h1000, 1'b1, 1'b1, 4'd12, 16'h1000};
    tbl[11] = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd12, 16'h0000};
    tbl[12] = '{1'b0, 16'h00F0, 1'b0, 1'b0, 4'd12, 16'h0000};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd12, 16'h0000};

    // reset held with all requests active
    bus.enable = 1'b1;
    bus.req = 16'hFFFF;
    bus.ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_idx", int'(bus.idx), 0);
    chk("reset_pending", int'(bus.pending), 0);
    reset_n = 1'b1;
    cycle(1'b1, 16'hFFFF, 1'b0);
    chk("release_valid", int'(bus.valid), 1);
    chk("release_idx", int'(bus.idx), 15);

    do_reset();
    foreach (tbl[k]) begin
      cycle(tbl[k].en, tbl[k].req, tbl[k].ack);
      chk($sformatf("tbl%0d_valid", k), int'(bus.valid), int'(tbl[k].v));
      chk($sformatf("tbl%0d_idx", k), int'(bus.idx), int'(tbl[k].idx));
      chk($sformatf("tbl%0d_pend", k), int'(bus.pending), int'(tbl[k].pend));
    end

    // asynchronous reset in the middle of a grant
    do_reset();
    cycle(1'b1, 16'h0300, 1'b0);
    chk("async_pre_valid", int'(bus.valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", int'(bus.valid), 0);
    chk("async_pending", int'(bus.pending), 0);
    chk("async_idx", int'(bus.idx), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();

    // all requests held with ack held: rotation or fixed top priority
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cycle(1'b1, 16'hFFFF, 1'b1);
      chk($sformatf("all_valid%0d", k), int'(bus.valid), 1);
      chk($sformatf("all_pend%0d", k), int'(bus.pending), 16'hFFFF);
`ifdef ENCODER_ROUND_ROBIN_EN
      chk($sformatf("all_idx%0d", k), int'(bus.idx), (31 - k) % 16);
`else
      chk($sformatf("all_idx%0d", k), int'(bus.idx), 15);
`endif
    end

    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic e, a;
      logic [15:0] r;
      e = $urandom_range(0, 4) != 0;
      a = $urandom_range(0, 2) != 0;
      r = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
      cycle(e, r, a);
      chk($sformatf("rnd%0d_valid", k), int'(bus.valid), int'(m_valid));
      chk($sformatf("rnd%0d_idx", k), int'(bus.idx), m_idx);
      chk($sformatf("rnd%0d_pend", k), int'(bus.pending), int'(m_pend));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/encoder_16x4_arb.md
Name: encoder_16x4_arb

Overview:
Registered 16-to-4 request encoder; the inverse of the 4x16 one-hot select decoder.
- Captures up to 16 request lines into a pending register.
- Presents one encoded 4-bit index at a time with valid.
- Clears each serviced request on a valid/ack handshake.
- Used by the ARMSIM core to turn per-unit event and request lines back into a register/source number.

Parameters:
N, 16, number of request lines (fixed at 16 for this block)
IW, 4, index width; must equal log2(N)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  request-capture enable; when 0, req is ignored
req  input  16  request pulses/levels, OR-ed into pending when enable=1
ack  input  1  consumer accepts the current idx; honoured only when valid=1
idx  output  4  encoded index of the granted request (registered)
valid  output  1  idx is meaningful (registered)
pending  output  16  current pending-request register (status)

Behaviour:
- Reset (reset_n=0, async): pending=0, idx=0, valid=0, state=IDLE. Takes effect mid-handshake too; no grant survives reset.
- ackmask = onehot(idx) when (valid & ack), else 0.
- pending_nxt = (pending & ~ackmask) | (enable ? req : 0).
  - Set wins: req on the bit being acked in the same cycle leaves it pending; it will be granted again.
- Priority, fixed: highest set index wins (bit 15 highest, bit 0 lowest).
- State machine, 2 states:
  - IDLE (valid=0): each edge loads idx <= enc(pending_nxt), valid <= |pending_nxt; if non-zero → GRANT.
  - GRANT (valid=1): idx held stable while ack=0, even if a higher-priority request arrives (lock rule).
  - GRANT on ack=1: load idx <= enc(pending_nxt), valid <= |pending_nxt. Stays in GRANT if non-zero, else → IDLE.
- Throughput: one grant per cycle with ack held high; no bubble.
- Latency: req sampled on edge E appears as valid/idx immediately after E (1 cycle).
- ack with valid=0 is ignored; no state change.
- enable=0 blocks capture only; already-pending bits are still granted and cleared normally.
- Re-asserting req on an already-pending bit has no extra effect; requests do not count.
- idx is only meaningful when valid=1; when valid=0 it holds the value last loaded (0 after reset).

Optional Feature:
Macro ENCODER_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - A 4-bit pointer rr_ptr resets to 15.
  - enc() searches downward from rr_ptr, wrapping 0→15.
  - On each accepted grant of index k, rr_ptr <= k-1 (mod 16).
  - No starvation: with all 16 bits continuously requested, every index is granted once per 16 acks.
- Undefined: fixed highest-index priority as above; no pointer register.

Decomposition:
- Shared package (encoder_pkg): IW/N constants, state typedef {IDLE, GRANT}, onehot-to-index width constants reused by the decoder side.
- One natural sub-module: prio_enc16, purely combinational.
  - Inputs: 16-bit vector and 4-bit start pointer (tied to 15 when the macro is off).
  - Outputs: 4-bit index and any-set flag.
  - Instantiated once on pending_nxt.

Test Plan:
- Reset: hold reset_n=0 with req=16'hFFFF, enable=1 → valid=0, idx=0, pending=0. Release → after next edge valid=1, idx=15.
- Single request: req=16'h0001 for 1 cycle → next cycle valid=1, idx=0. ack=1 one cycle → valid=0, pending=0.
- Back-to-back: req=16'h8421 one cycle, ack held 1 → idx sequence 15,10,5,0 on 4 consecutive cycles, then valid=0.
- Lock and set-wins:
  - While idx=5 granted, ack=0, pulse req[12] → idx stays 5.
  - Then ack → idx=12.
  - Separately, ack and req on the same bit in one cycle → that bit re-granted next.
- enable and reset mid-operation:
  - enable=0, req=16'h00F0 → valid stays 0.
  - With grant active, assert reset_n=0 asynchronously between edges → valid=0 immediately, pending=0.
- ENCODER_ROUND_ROBIN_EN build: req=16'hFFFF held, ack held → idx 15,14,…,0,15 over 17 cycles.
- Non-RR build, same stimulus: idx=15 on every cycle.
